// File: rtl/pixel_packer_pkg.sv
// Shared types and constants for the CMV300 pixel packer.
package pixel_packer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        FLUSH
    } pp_state_t;

    localparam logic [7:0]  HDR_TAG      = 8'hA5;
    localparam int unsigned SLOTS_MODE8  = 4;
    localparam int unsigned SLOTS_MODE16 = 2;

    // Decimation factor 0 behaves like 1.
    function automatic logic [1:0] decim_eff(input logic [1:0] d);
        return (d == 2'd0) ? 2'd1 : d;
    endfunction

endpackage

// File: rtl/roi_filter.sv
// Row/column tracking, ROI window and decimation phase for the pixel packer.
module roi_filter
    import pixel_packer_pkg::*;
#(
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 9
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             armed,
    input  logic             active,
    input  logic             line_valid,
    input  logic             data_valid,
    input  logic [COL_W-1:0] x0,
    input  logic [COL_W-1:0] x1,
    input  logic [ROW_W-1:0] y0,
    input  logic [ROW_W-1:0] y1,
    input  logic [1:0]       decim,
    output logic             line_rise,
    output logic             pix_accept,
    output logic             frame_end
);
    localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

    logic             lv_d;
    logic             line_fall;
    logic             en;
    logic             sample;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [1:0]       col_ph;
    logic [1:0]       row_ph;
    logic [1:0]       ph_max;
    logic             x_in;
    logic             y_in;

    assign line_rise = line_valid & ~lv_d;
    assign line_fall = ~line_valid & lv_d;
    // The line that triggers ARMED->ACTIVE is counted from its first sample.
    assign en        = active | (armed & line_rise);
    assign sample    = en & line_valid & data_valid;
    assign ph_max    = decim_eff(decim) - 2'd1;
    assign x_in      = (col >= x0) && (col <= x1);
    assign y_in      = (row >= y0) && (row <= y1);

    assign pix_accept = sample & x_in & y_in & (col_ph == 2'd0) & (row_ph == 2'd0);
    assign frame_end  = en & line_fall & ((row == y1) || (y1 < y0));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lv_d   <= 1'b0;
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else begin
            lv_d <= line_valid;
            if (clear) begin
                col    <= '0;
                row    <= '0;
                col_ph <= '0;
                row_ph <= '0;
            end else if (en) begin
                if (line_fall) begin
                    col    <= '0;
                    col_ph <= '0;
                    row    <= (row == '1) ? row : row + ROW_ONE;
                    if (row >= y0)
                        row_ph <= (row_ph == ph_max) ? 2'd0 : row_ph + 2'd1;
                end else if (sample) begin
                    col <= (col == '1) ? col : col + COL_ONE;
                    if (col >= x0)
                        col_ph <= (col_ph == ph_max) ? 2'd0 : col_ph + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Crops, decimates and packs CMV300 pixels into 32-bit FIFO words.
// Optional frame header word enabled by defining PIXEL_PACKER_HEADER_EN.
module pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter int unsigned PIX_W  = 10,
    parameter int unsigned COL_W  = 10,
    parameter int unsigned ROW_W  = 9,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              frame_start,
    input  logic [PIX_W-1:0]  pix_d,
    input  logic              line_valid,
    input  logic              data_valid,
    input  logic [COL_W-1:0]  roi_x0,
    input  logic [COL_W-1:0]  roi_x1,
    input  logic [ROW_W-1:0]  roi_y0,
    input  logic [ROW_W-1:0]  roi_y1,
    input  logic [1:0]        decim,
    input  logic              mode,
    input  logic              fifo_full,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              frame_done,
    output logic              overflow,
    output logic [19:0]       word_count
);
    pp_state_t         state, state_n;
    logic [COL_W-1:0]  cfg_x0, cfg_x1;
    logic [ROW_W-1:0]  cfg_y0, cfg_y1;
    logic [1:0]        cfg_decim;
    logic              cfg_mode;

    logic [WORD_W-1:0] pack, pack_n;
    logic [1:0]        slot, slot_n;
    logic [1:0]        last_slot;
    logic [WORD_W-1:0] lane;
    logic [WORD_W-1:0] emit_word;
    logic              emit;
    logic              done_n;
    logic              line_rise;
    logic              pix_accept;
    logic              frame_end;
    logic [7:0]        pix8;
    logic [15:0]       pix16;
`ifdef PIXEL_PACKER_HEADER_EN
    logic [15:0]       frame_cnt;
`endif

    roi_filter #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_roi (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (frame_start),
        .armed      (state == ARMED),
        .active     (state == ACTIVE),
        .line_valid (line_valid),
        .data_valid (data_valid),
        .x0         (cfg_x0),
        .x1         (cfg_x1),
        .y0         (cfg_y0),
        .y1         (cfg_y1),
        .decim      (cfg_decim),
        .line_rise  (line_rise),
        .pix_accept (pix_accept),
        .frame_end  (frame_end)
    );

    assign pix8      = pix_d[PIX_W-1 -: 8];
    assign pix16     = 16'(pix_d);
    assign last_slot = cfg_mode ? 2'(SLOTS_MODE16 - 1) : 2'(SLOTS_MODE8 - 1);

    always_comb begin
        lane = '0;
        if (cfg_mode) begin
            lane = slot[0] ? {pix16, 16'h0000} : {16'h0000, pix16};
        end else begin
            case (slot)
                2'd0:    lane = {24'h000000, pix8};
                2'd1:    lane = {16'h0000, pix8, 8'h00};
                2'd2:    lane = {8'h00, pix8, 16'h0000};
                default: lane = {pix8, 24'h000000};
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        pack_n    = pack;
        slot_n    = slot;
        emit      = 1'b0;
        emit_word = '0;
        done_n    = 1'b0;
        if (frame_start) begin
            state_n = ARMED;
            pack_n  = '0;
            slot_n  = '0;
        end else begin
            case (state)
                ARMED: begin
                    if (line_rise) begin
                        state_n = ACTIVE;
`ifdef PIXEL_PACKER_HEADER_EN
                        emit      = 1'b1;
                        emit_word = {HDR_TAG, cfg_mode, 7'd0, frame_cnt};
`endif
                    end
                end
                ACTIVE: begin
                    if (frame_end)
                        state_n = FLUSH;
                end
                FLUSH: begin
                    // Partial word goes out first; frame_done follows on the next pass.
                    if (slot != 2'd0) begin
                        emit      = 1'b1;
                        emit_word = pack;
                        pack_n    = '0;
                        slot_n    = '0;
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
            if (pix_accept) begin
                if (slot == last_slot) begin
                    emit      = 1'b1;
                    emit_word = pack | lane;
                    pack_n    = '0;
                    slot_n    = '0;
                end else begin
                    pack_n = pack | lane;
                    slot_n = slot + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_x0     <= '0;
            cfg_x1     <= '0;
            cfg_y0     <= '0;
            cfg_y1     <= '0;
            cfg_decim  <= '0;
            cfg_mode   <= 1'b0;
            pack       <= '0;
            slot       <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            pack       <= pack_n;
            slot       <= slot_n;
            frame_done <= done_n;
            word_valid <= emit & ~fifo_full;
            if (emit && !fifo_full)
                word_data <= emit_word;
            if (frame_start) begin
                cfg_x0     <= roi_x0;
                cfg_x1     <= roi_x1;
                cfg_y0     <= roi_y0;
                cfg_y1     <= roi_y1;
                cfg_decim  <= decim;
                cfg_mode   <= mode;
                overflow   <= 1'b0;
                word_count <= '0;
            end else if (emit) begin
                if (fifo_full)
                    overflow <= 1'b1;
                else
                    word_count <= word_count + 20'd1;
            end
        end
    end

`ifdef PIXEL_PACKER_HEADER_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            frame_cnt <= '0;
        else if (done_n)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// Directed self-checking bench for pixel_packer (handles both header builds).
module tb_pixel_packer;

`ifdef PIXEL_PACKER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_start;
    logic [9:0]  pix_d;
    logic        line_valid;
    logic        data_valid;
    logic [9:0]  roi_x0, roi_x1;
    logic [8:0]  roi_y0, roi_y1;
    logic [1:0]  decim;
    logic        mode;
    logic        fifo_full;
    logic [31:0] word_data;
    logic        word_valid;
    logic        frame_done;
    logic        overflow;
    logic [19:0] word_count;

    always #5 clk = ~clk;

    pixel_packer #(
        .PIX_W  (10),
        .COL_W  (10),
        .ROW_W  (9),
        .WORD_W (32)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_start (frame_start),
        .pix_d       (pix_d),
        .line_valid  (line_valid),
        .data_valid  (data_valid),
        .roi_x0      (roi_x0),
        .roi_x1      (roi_x1),
        .roi_y0      (roi_y0),
        .roi_y1      (roi_y1),
        .decim       (decim),
        .mode        (mode),
        .fifo_full   (fifo_full),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .word_count  (word_count)
    );

    int unsigned cyc = 0;
    logic [31:0] words[$];
    int          done_cnt = 0;
    int unsigned last_word_cyc = 0;
    int unsigned done_cyc = 0;
    int          full_viol = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (word_valid) begin
            words.push_back(word_data);
            last_word_cyc = cyc;
            if (fifo_full) full_viol++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Pixel (c,r): bits [9:8] = r, bits [7:4] = c, so pix_d[9:2] = {r, c, 2'b00}.
    function automatic logic [9:0] pix(input int c, input int r);
        return 10'(((r % 4) << 8) | ((c % 16) << 4));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic scramble_cfg();
        roi_x0 = 10'h3FF; roi_x1 = 10'h000;
        roi_y0 = 9'h1FF;  roi_y1 = 9'h000;
        decim  = 2'd3;    mode   = ~mode;
    endtask

    task automatic start_frame(input int x0, input int x1, input int y0, input int y1,
                               input int d, input logic m);
        step();
        roi_x0 = 10'(x0); roi_x1 = 10'(x1);
        roi_y0 = 9'(y0);  roi_y1 = 9'(y1);
        decim  = 2'(d);   mode   = m;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        scramble_cfg();
        words.delete();
        done_cnt = 0;
    endtask

    // full_col < 0: fifo_full stays low; else high from that column for a few cycles.
    task automatic send_line(input int r, input int ncols, input int full_col);
        for (int c = 0; c < ncols; c++) begin
            step();
            line_valid = 1'b1;
            data_valid = 1'b1;
            pix_d      = pix(c, r);
            fifo_full  = (full_col >= 0) && (c >= full_col);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            line_valid = 1'b0;
            data_valid = 1'b0;
            pix_d      = '0;
            if (i == 2) fifo_full = 1'b0;
        end
    endtask

    initial begin
        resetn = 1'b0; frame_start = 1'b0; pix_d = '0;
        line_valid = 1'b0; data_valid = 1'b0; fifo_full = 1'b0;
        roi_x0 = '0; roi_x1 = '0; roi_y0 = '0; roi_y1 = '0; decim = '0; mode = 1'b0;
        idle(3);
        check("rst_word_data", word_data, 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_word_count", 32'(word_count), 32'h0);
        resetn = 1'b1;
        idle(2);

`ifdef PIXEL_PACKER_HEADER_EN
        start_frame(0, 7, 0, 0, 1, 1'b0);
        send_line(0, 8, -1);
        idle(6);
        check("hdr_f0_nwords", 32'(words.size()), 32'd3);
        check("hdr_f0_word0", words[0], 32'hA500_0000);
        check("hdr_f0_word1", words[1], 32'h0C08_0400);
        check("hdr_f0_count", 32'(word_count), 32'd3);
        start_frame(0, 7, 0, 0, 1, 1'b0);
        send_line(0, 8, -1);
        idle(6);
        check("hdr_f1_word0", words[0], 32'hA500_0001);
        check("hdr_f1_done", 32'(done_cnt), 32'd1);
`endif

        // Mode 0 crop of one 8-pixel line.
        start_frame(0, 7, 0, 0, 1, 1'b0);
        send_line(0, 8, -1);
        idle(6);
        check("m0_nwords", 32'(words.size()), 32'(2 + HDR));
        check("m0_word0", words[HDR], 32'h0C08_0400);
        check("m0_word1", words[HDR + 1], 32'h1C18_1410);
        check("m0_done", 32'(done_cnt), 32'd1);
        check("m0_count", 32'(word_count), 32'(2 + HDR));
        check("m0_overflow", 32'(overflow), 32'h0);
        check("m0_done_gap", done_cyc - last_word_cyc, 32'd2);

        // Mode 1, 3-pixel ROI on row 1 -> zero-padded flush word.
        start_frame(2, 4, 1, 1, 1, 1'b1);
        for (int r = 0; r < 3; r++) send_line(r, 8, -1);
        idle(6);
        check("m1_nwords", 32'(words.size()), 32'(2 + HDR));
        check("m1_word0", words[HDR], 32'h0130_0120);
        check("m1_word1_flush", words[HDR + 1], 32'h0000_0140);
        check("m1_done", 32'(done_cnt), 32'd1);
        check("m1_done_gap", done_cyc - last_word_cyc, 32'd1);

        // Decimation by 2 over 8x4.
        start_frame(0, 7, 0, 3, 2, 1'b0);
        for (int r = 0; r < 4; r++) send_line(r, 8, -1);
        idle(6);
        check("dec_nwords", 32'(words.size()), 32'(2 + HDR));
        check("dec_word0", words[HDR], 32'h1810_0800);
        check("dec_word1", words[HDR + 1], 32'h9890_8880);
        check("dec_done", 32'(done_cnt), 32'd1);
        check("dec_count", 32'(word_count), 32'(2 + HDR));

        // Overflow on the second word; decim 0 acts as 1.
        start_frame(0, 7, 0, 0, 0, 1'b0);
        send_line(0, 8, 6);
        idle(6);
        check("ovf_nwords", 32'(words.size()), 32'(1 + HDR));
        check("ovf_word0", words[HDR], 32'h0C08_0400);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_count", 32'(word_count), 32'(1 + HDR));
        check("ovf_done", 32'(done_cnt), 32'd1);
        check("ovf_wv_while_full", 32'(full_viol), 32'd0);
        idle(5);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Abort mid-row, then a new frame with a different ROI.
        start_frame(0, 7, 0, 0, 1, 1'b0);
        check("ovf_cleared", 32'(overflow), 32'h0);
        for (int c = 0; c < 6; c++) begin
            step();
            line_valid = 1'b1; data_valid = 1'b1; pix_d = pix(c, 0);
        end
        step();
        roi_x0 = 10'd4; roi_x1 = 10'd7; roi_y0 = 9'd0; roi_y1 = 9'd0;
        decim = 2'd1; mode = 1'b0;
        frame_start = 1'b1; pix_d = pix(6, 0);
        step();
        frame_start = 1'b0; pix_d = pix(7, 0);
        scramble_cfg();
        step();
        line_valid = 1'b0; data_valid = 1'b0; pix_d = '0;
        idle(4);
        check("abt_nwords", 32'(words.size()), 32'(1 + HDR));
        check("abt_word0", words[HDR], 32'h0C08_0400);
        check("abt_no_done", 32'(done_cnt), 32'd0);
        check("abt_count_clr", 32'(word_count), 32'd0);
        words.delete();
        send_line(0, 8, -1);
        idle(6);
        check("abt_new_nwords", 32'(words.size()), 32'(1 + HDR));
        check("abt_new_word", words[HDR], 32'h1C18_1410);
        check("abt_new_done", 32'(done_cnt), 32'd1);
        check("abt_new_count", 32'(word_count), 32'(1 + HDR));

        // Inverted row bounds: frame ends after the first line.
        start_frame(0, 7, 3, 1, 1, 1'b0);
        send_line(0, 8, -1);
        idle(6);
        check("invy_nwords", 32'(words.size()), 32'(HDR));
        check("invy_done", 32'(done_cnt), 32'd1);
        check("invy_count", 32'(word_count), 32'(HDR));

        // Inverted column bounds: no pixels, frame_done at end of row 0.
        start_frame(5, 2, 0, 0, 1, 1'b1);
        send_line(0, 8, -1);
        idle(6);
        check("invx_nwords", 32'(words.size()), 32'(HDR));
        check("invx_done", 32'(done_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
